// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the architectural PC and selects the next PC from PCSrc. It fetches one
//   instruction at a time over a req/ready + rvalid instruction-memory handshake.
//   Only one request is in flight at a time. A one-entry buffer feeds decode.
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-high reset
//   PCSrc             next-PC select: 00 PC+4, 01 PCTarget, 10 ALUResult (JALR), 11 PC+4
//   PCTarget          branch/JAL target from execute
//   ALUResult         JALR target from the ALU
//   StallF            decode not ready; the buffered instruction is held
//   imem_req          fetch request valid (asserted in REQ)
//   imem_addr         fetch address, always equal to PCF
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid       read data valid (only looked at in WAIT)
//   imem_rdata        read data
//   PCF, PCPlus4F     current fetch PC and PCF+4
//   InstrF            buffered instruction; NOP_INSTR when InstrValidF=0
//   InstrValidF       InstrF holds a fetched instruction
//   FetchRetry        one-cycle pulse in the REQ cycle that re-issues a timed-out request
//   Misalign          one-cycle pulse after a misaligned redirect
//
// Build option
//   PC_MISALIGN_TRAP_EN  when defined, a misaligned next PC redirects to TRAP_PC and
//                        pulses Misalign. When undefined, next PC[1:0] is forced to 00
//                        and Misalign stays 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset; moves to REQ on the next cycle
// REQ   | imem_req high at PCF, waiting for imem_ready
// WAIT  | request accepted, waiting for rvalid; re-issues after MAX_WAIT cycles
// VALID | instruction buffered for decode; consumed when StallF=0
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          MAX_WAIT  = 16,
  parameter logic [31:0] TRAP_PC   = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        StallF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic        FetchRetry,
  output logic        Misalign
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [31:0]   pc_q, pc_n;
  logic [31:0]   instr_q, instr_n;
  logic          valid_q, valid_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          retry_q, retry_n;
  logic          mis_q, mis_n;

  logic [31:0]   pc_plus4;
  logic [31:0]   pc_sel;
  logic [31:0]   pc_next;
  logic          misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_sel = pc_plus4;
    case (PCSrc)
      2'b01:   pc_sel = PCTarget;
      2'b10:   pc_sel = {ALUResult[31:1], 1'b0};
      default: pc_sel = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = |pc_sel[1:0];
  assign pc_next    = misaligned ? TRAP_PC : pc_sel;
`else
  assign misaligned = 1'b0;
  assign pc_next    = pc_sel & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      retry_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      cnt_q   <= cnt_n;
      retry_q <= retry_n;
      mis_q   <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    valid_n = valid_q;
    cnt_n   = cnt_q;
    retry_n = 1'b0;
    mis_n   = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        // rvalid in the accept cycle belongs to nothing we issued; ignore it
        if (imem_ready) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_n = VALID;
          instr_n = imem_rdata;
          valid_n = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_n = REQ;
          retry_n = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      VALID: begin
        if (!StallF) begin
          state_n = REQ;
          pc_n    = pc_next;
          instr_n = NOP_INSTR;
          valid_n = 1'b0;
          mis_n   = misaligned;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc_q;
  assign PCF         = pc_q;
  assign PCPlus4F    = pc_plus4;
  assign InstrF      = instr_q;
  assign InstrValidF = valid_q;
  assign FetchRetry  = retry_q;
  assign Misalign    = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          MAX_WAIT  = 16;
  localparam logic [31:0] TRAP_PC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = '0;
  logic [31:0] ALUResult = '0;
  logic        StallF = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PCF, PCPlus4F, InstrF;
  logic        InstrValidF, FetchRetry, Misalign;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] mpc;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .MAX_WAIT(MAX_WAIT), .TRAP_PC(TRAP_PC)
  ) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .ALUResult(ALUResult),
    .StallF(StallF), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .FetchRetry(FetchRetry), .Misalign(Misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Drives one fetch from REQ through to VALID; ends at the negedge where VALID is visible.
  task automatic do_fetch(input int ready_wait, input int rv_wait, input bit early_rv,
                          output int acc_cyc);
    logic [31:0] exp, ins;
    wait_req();
    check("sb_addr_nonempty", {31'd0, addr_q.size() != 0}, 32'd1);
    exp = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hBAD0_BAD0;
    imem_ready = 1'b0;
    for (int i = 0; i < ready_wait; i++) begin
      @(negedge clk);
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_held", imem_addr, exp);
    end
    check("fetch_addr", imem_addr, exp);
    imem_ready = 1'b1;
    if (early_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    acc_cyc = cyc;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    check("wait_req_low", {31'd0, imem_req}, 32'd0);
    check("wait_not_valid", {31'd0, InstrValidF}, 32'd0);
    check("wait_misalign_low", {31'd0, Misalign}, 32'd0);
    check("wait_retry_low", {31'd0, FetchRetry}, 32'd0);
    for (int i = 0; i < rv_wait; i++) @(negedge clk);
    ins = mem_data(exp);
    imem_rvalid = 1'b1;
    imem_rdata  = ins;
    instr_q.push_back(ins);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("instr_valid", {31'd0, InstrValidF}, 32'd1);
    check("instr_data", InstrF, instr_q.pop_front());
    check("pcf", PCF, exp);
    check("pcplus4", PCPlus4F, exp + 32'd4);
    if (rv_wait == 0) check("latency", cyc - acc_cyc, 32'd2);
  endtask

  // Called at the VALID negedge; stalls, then consumes with the given next-PC selection.
  task automatic consume(input int stall, input logic [1:0] src,
                         input logic [31:0] tgt, input logic [31:0] alu);
    logic [31:0] held, n;
    bit mis;
    held = InstrF;
    StallF = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, InstrValidF}, 32'd1);
      check("stall_instr", InstrF, held);
      check("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    case (src)
      2'b01:   n = tgt;
      2'b10:   n = alu & 32'hFFFF_FFFE;
      default: n = mpc + 32'd4;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    mis = (n[1:0] != 2'b00);
    if (mis) n = TRAP_PC;
`else
    mis = 1'b0;
    n = n & 32'hFFFF_FFFC;
`endif
    mpc = n;
    addr_q.push_back(n);
    StallF = 1'b0;
    PCSrc = src;
    PCTarget = tgt;
    ALUResult = alu;
    @(negedge clk);
    PCSrc = 2'b11;
    PCTarget = 32'hFFFF_FFFF;
    ALUResult = 32'hFFFF_FFFF;
    check("consume_not_valid", {31'd0, InstrValidF}, 32'd0);
    check("consume_nop", InstrF, NOP_INSTR);
    check("consume_pcf", PCF, n);
    check("consume_misalign", {31'd0, Misalign}, {31'd0, mis});
  endtask

  task automatic timeout_fetch();
    logic [31:0] exp;
    int acc;
    wait_req();
    exp = (addr_q.size() != 0) ? addr_q[0] : 32'hBAD0_BAD0;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_req_held", {31'd0, imem_req}, 32'd1);
      check("to_addr_held", imem_addr, exp);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    for (int i = 1; i < MAX_WAIT; i++) begin
      check("to_wait_req", {31'd0, imem_req}, 32'd0);
      check("to_wait_retry", {31'd0, FetchRetry}, 32'd0);
      @(negedge clk);
    end
    check("to_last_wait_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("retry_req", {31'd0, imem_req}, 32'd1);
    check("retry_pulse", {31'd0, FetchRetry}, 32'd1);
    check("retry_addr", imem_addr, exp);
    do_fetch(0, 0, 1'b0, acc);
  endtask

  initial begin
    int a1, a2, a3, tmp;

    // reset state
    @(negedge clk);
    check("rst_pcf", PCF, RESET_PC);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, InstrValidF}, 32'd0);
    check("rst_instr", InstrF, NOP_INSTR);
    check("rst_retry", {31'd0, FetchRetry}, 32'd0);
    check("rst_misalign", {31'd0, Misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mpc = RESET_PC;
    addr_q.push_back(RESET_PC);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);

    // 1: sequential fetch, throughput 1 per 3 cycles
    do_fetch(0, 0, 1'b0, a1);
    consume(0, 2'b00, '0, '0);
    do_fetch(0, 0, 1'b0, a2);
    consume(0, 2'b00, '0, '0);
    do_fetch(0, 0, 1'b0, a3);
    check("thru_1", a2 - a1, 32'd3);
    check("thru_2", a3 - a2, 32'd3);

    // 2: move to 0x20, stall 5 cycles, then branch to 0x40
    consume(0, 2'b01, 32'h0000_0020, '0);
    do_fetch(0, 2, 1'b0, tmp);
    consume(5, 2'b01, 32'h0000_0040, '0);
    do_fetch(0, 0, 1'b0, tmp);

    // 3: JALR to 0x83
    consume(0, 2'b10, '0, 32'h0000_0083);

    // 4: ready held low, then read timeout and re-issue
    timeout_fetch();

    // 5: wrap at top of address space, then reset in WAIT
    consume(0, 2'b01, 32'hFFFF_FFFC, '0);
    do_fetch(0, 0, 1'b0, tmp);
    consume(0, 2'b00, '0, '0);
    do_fetch(0, 0, 1'b0, tmp);
    consume(0, 2'b01, 32'h0000_0044, '0);
    wait_req();
    check("pre_reset_addr", imem_addr, addr_q.size() != 0 ? addr_q.pop_front() : 32'hBAD0_BAD0);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_pcf", PCF, RESET_PC);
    check("midrst_valid", {31'd0, InstrValidF}, 32'd0);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_instr", InstrF, NOP_INSTR);
    @(negedge clk);
    reset = 1'b0;
    addr_q.delete();
    instr_q.delete();
    mpc = RESET_PC;
    addr_q.push_back(RESET_PC);
    do_fetch(0, 0, 1'b1, tmp);
    check("sb_drained", addr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
